panda_risc_v_wbk: RTL

Write-back stage directly downstream of the commit unit. It consumes each delivered instruction's commit result (confirmed/cancelled, immediate-writeback flag). It writes short-instruction ALU results to the integer register file at once. Long instructions (L/S, mul/div) are tracked in an in-order pending queue; their later results are written back, or discarded if the instruction was cancelled. It has a single registered register-file write port.

---
 rtl/panda_risc_v_pkg.sv | 16 +
 rtl/panda_risc_v_wbk_pending_fifo.sv | 41 ++++
 rtl/panda_risc_v_wbk.sv | 80 ++++++++
 3 files changed

// File: rtl/panda_risc_v_pkg.sv
// Shared types and constants for the panda_risc_v write-back stage.
package panda_risc_v_pkg;

  localparam int REG_ID_WIDTH = 5;
  localparam logic [REG_ID_WIDTH-1:0] X0_ID = '0;

  // One outstanding long instruction, recorded at commit time
  typedef struct packed {
    logic [REG_ID_WIDTH-1:0] rd_id;
    logic                    cmt;
    logic                    rd_vld;
  } pend_entry_t;

  localparam int PEND_ENTRY_WIDTH = $bits(pend_entry_t);

endpackage

// File: rtl/panda_risc_v_wbk_pending_fifo.sv
// In-order pending queue for long instructions; extra pointer bit separates full from empty.
module panda_risc_v_wbk_pending_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW:0]                 wr_ptr;
  logic [AW:0]                 rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/panda_risc_v_wbk.sv
// Write-back stage: immediate short-result writes plus in-order retirement of long results.
module panda_risc_v_wbk
  import panda_risc_v_pkg::*;
#(
  parameter int  LONG_FIFO_DEPTH  = 4,
  parameter real simulation_delay = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    s_pst_inst_cmt,
  input  logic                    s_pst_wb_imdt,
  input  logic                    s_pst_rd_vld,
  input  logic                    s_pst_is_long_inst,
  input  logic [REG_ID_WIDTH-1:0] s_pst_rd_id,
  input  logic [31:0]             s_pst_alu_res,
  input  logic                    s_pst_valid,
  output logic                    s_pst_ready,
  input  logic [31:0]             s_long_res_data,
  input  logic                    s_long_res_err,
  input  logic                    s_long_res_valid,
  output logic                    s_long_res_ready,
  output logic                    reg_file_wen,
  output logic [REG_ID_WIDTH-1:0] reg_file_waddr,
  output logic [31:0]             reg_file_wdat,
  output logic                    long_pending_empty,
  output logic                    long_pending_full
);

  pend_entry_t push_entry;
  pend_entry_t head;
  logic        push;
  logic        pop;
  logic        imm_wr;
  logic        long_wr;

  // Full blocks long instructions regardless of a same-cycle pop
  assign s_pst_ready      = ~(s_pst_is_long_inst & long_pending_full);
  assign push             = s_pst_valid & s_pst_ready & s_pst_is_long_inst;
  assign imm_wr           = s_pst_valid & s_pst_ready & s_pst_wb_imdt & s_pst_inst_cmt;
  assign s_long_res_ready = ~long_pending_empty & ~imm_wr;
  assign pop              = s_long_res_valid & s_long_res_ready;

  // Cancelled long instructions are still queued so their result gets drained
  assign push_entry = '{rd_id: s_pst_rd_id, cmt: s_pst_inst_cmt, rd_vld: s_pst_rd_vld};

  assign long_wr = pop & head.cmt & head.rd_vld & ~s_long_res_err & (head.rd_id != X0_ID);

  panda_risc_v_wbk_pending_fifo #(
    .DEPTH(LONG_FIFO_DEPTH),
    .WIDTH(PEND_ENTRY_WIDTH)
  ) u_pending_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .empty     (long_pending_empty),
    .full      (long_pending_full)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reg_file_wen   <= 1'b0;
      reg_file_waddr <= '0;
      reg_file_wdat  <= '0;
    end else if (imm_wr && (s_pst_rd_id != X0_ID)) begin
      reg_file_wen   <= 1'b1;
      reg_file_waddr <= s_pst_rd_id;
      reg_file_wdat  <= s_pst_alu_res;
    end else if (long_wr) begin
      reg_file_wen   <= 1'b1;
      reg_file_waddr <= head.rd_id;
      reg_file_wdat  <= s_long_res_data;
    end else begin
      reg_file_wen   <= 1'b0;
    end
  end

endmodule
